// File: rtl/multi_way_traffic_controller_pkg.sv
// traffic_pkg: phase encoding and sizing helper shared by the traffic controller files
package traffic_pkg;
  typedef enum logic [1:0] {GREEN = 2'd0, YELLOW = 2'd1, ALLRED = 2'd2} phase_e;
  localparam logic [1:0] S_GREEN = GREEN;
  localparam logic [1:0] S_YELLOW = YELLOW;
  localparam logic [1:0] S_ALLRED = ALLRED;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction
endpackage

// File: rtl/multi_way_traffic_controller_if.sv
// multi_way_traffic_controller_if: sensor/pre-emption inputs and lamp/status outputs of the controller
interface multi_way_traffic_controller_if #(
  parameter int N_WAYS = 4
);
  localparam int W = $clog2(N_WAYS);
  logic [N_WAYS-1:0] sensor;
  logic              emerg_req;
  logic [W-1:0]      emerg_way;
  logic [N_WAYS-1:0] red;
  logic [N_WAYS-1:0] yellow;
  logic [N_WAYS-1:0] green;
  logic [W-1:0]      active_way;
  logic [1:0]        phase;
  modport master (
    output sensor, emerg_req, emerg_way,
    input  red, yellow, green, active_way, phase
  );
  modport slave (
    input  sensor, emerg_req, emerg_way,
    output red, yellow, green, active_way, phase
  );
endinterface

// File: rtl/multi_way_traffic_controller_rr_next_way.sv
// rr_next_way: first requesting way after active_way, wrapping, excluding active_way itself
module rr_next_way #(
  parameter int N_WAYS = 4,
  localparam int W = $clog2(N_WAYS)
) (
  input  logic [N_WAYS-1:0] sensor,
  input  logic [W-1:0]      active_way,
  output logic              found,
  output logic [W-1:0]      next
);
  // scan farthest to nearest so the nearest requester wins
  always_comb begin
    found = 1'b0;
    next = active_way;
    for (int k = N_WAYS - 1; k >= 1; k--) begin
      if (sensor[(int'(active_way) + k) % N_WAYS]) begin
        found = 1'b1;
        next = W'((int'(active_way) + k) % N_WAYS);
      end
    end
  end
endmodule

// File: rtl/multi_way_traffic_controller.sv
// multi_way_traffic_controller: green/yellow/all-red sequencer with round-robin hand-over and pre-emption
module multi_way_traffic_controller
  import traffic_pkg::*;
#(
  parameter int N_WAYS = 4,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW_CYCLES = 3,
  parameter int ALLRED_CYCLES = 1
) (
  input logic clk,
  input logic reset,
  multi_way_traffic_controller_if.slave bus
);
  localparam int W = $clog2(N_WAYS);
  localparam int TW = $clog2(max3(MAX_GREEN, YELLOW_CYCLES, ALLRED_CYCLES)) + 1;
  logic [1:0]        state, state_n;
  logic [W-1:0]      active_way, way_n, next_way, next_n, rr_next;
  logic [TW-1:0]     timer, timer_n;
  logic              found, emerg, hold, give_way, last;
  logic [N_WAYS-1:0] green_q, yellow_q, red_q, green_n, yellow_n;
  rr_next_way #(.N_WAYS(N_WAYS)) u_rr (
    .sensor(bus.sensor),
    .active_way(active_way),
    .found(found),
    .next(rr_next)
  );
  assign emerg = bus.emerg_req && (int'(bus.emerg_way) < N_WAYS);
  always_comb begin
    state_n = state;
    way_n = active_way;
    next_n = next_way;
    timer_n = timer;
    last = 1'b0;
    hold = emerg && bus.emerg_way == active_way;
    give_way = found && (timer >= TW'(MAX_GREEN - 1) ||
                         (timer >= TW'(MIN_GREEN - 1) && !bus.sensor[active_way]));
    if (state == S_GREEN) begin
      if (emerg && !hold) begin
        state_n = S_YELLOW;
        next_n = bus.emerg_way;
        timer_n = '0;
      end else if (!hold && give_way) begin
        state_n = S_YELLOW;
        next_n = rr_next;
        timer_n = '0;
      end else begin
        timer_n = timer < TW'(MAX_GREEN) ? timer + 1'b1 : timer;
      end
    end else begin
      // only pre-emption may retarget the latched hand-over way here
      next_n = emerg ? bus.emerg_way : next_way;
      last = state == S_YELLOW ? timer == TW'(YELLOW_CYCLES - 1) : timer == TW'(ALLRED_CYCLES - 1);
      timer_n = last ? '0 : timer + 1'b1;
      if (last) begin
        state_n = (state == S_YELLOW && ALLRED_CYCLES > 0) ? S_ALLRED : S_GREEN;
        way_n = state_n == S_GREEN ? next_n : active_way;
      end
    end
    green_n = state_n == S_GREEN ? N_WAYS'(1) << way_n : '0;
    yellow_n = state_n == S_YELLOW ? N_WAYS'(1) << way_n : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_GREEN;
      active_way <= '0;
      next_way <= '0;
      timer <= '0;
      green_q <= N_WAYS'(1);
      yellow_q <= '0;
      red_q <= ~N_WAYS'(1);
    end else begin
      state <= state_n;
      active_way <= way_n;
      next_way <= next_n;
      timer <= timer_n;
      green_q <= green_n;
      yellow_q <= yellow_n;
      red_q <= ~(green_n | yellow_n);
    end
  end
  assign bus.green = green_q;
  assign bus.yellow = yellow_q;
  assign bus.red = red_q;
  assign bus.active_way = active_way;
  assign bus.phase = state;
endmodule

// File: tb/tb_multi_way_traffic_controller.sv
// tb_multi_way_traffic_controller: directed phase-length and hand-over checks with a per-cycle lamp monitor
module tb_multi_way_traffic_controller;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mon = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int bad;
  int ways [5] = '{1, 2, 3, 0, 1};
  multi_way_traffic_controller_if #(.N_WAYS(4)) bus ();
  multi_way_traffic_controller #(.N_WAYS(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int lamps_ok();
    int nr;
    nr = 0;
    for (int i = 0; i < 4; i++) begin
      if (int'(bus.red[i]) + int'(bus.green[i]) + int'(bus.yellow[i]) != 1) return 0;
      if (!bus.red[i]) nr++;
    end
    if (bus.green != (bus.phase == 2'd0 ? 4'b0001 << bus.active_way : 4'b0000)) return 0;
    if (bus.yellow != (bus.phase == 2'd1 ? 4'b0001 << bus.active_way : 4'b0000)) return 0;
    return int'(nr <= 1);
  endfunction
  always @(negedge clk) if (mon) check("one_lamp", lamps_ok(), 1);
  task automatic measure(output int n);
    logic [1:0] ph, w;
    ph = bus.phase;
    w = bus.active_way;
    n = 1;
    while (n < 200) begin
      @(negedge clk);
      if (bus.phase != ph || bus.active_way != w) break;
      n++;
    end
  endtask
  task automatic span(input string tag, input int ph, input int way, input int len);
    int n;
    check($sformatf("%s_phase", tag), bus.phase, ph);
    check($sformatf("%s_way", tag), bus.active_way, way);
    if (len > 0) begin
      measure(n);
      check($sformatf("%s_len", tag), n, len);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.sensor = '0;
    bus.emerg_req = 1'b0;
    bus.emerg_way = '0;
    repeat (2) @(negedge clk);
  endtask
  task automatic to_green2();
    do_reset();
    reset = 1'b0;
    bus.sensor = 4'b0100;
    span("g0", 0, 0, 4);
    span("y0", 1, 0, 3);
    span("r0", 2, 0, 1);
    span("g2", 0, 2, -1);
  endtask
  initial begin
    do_reset();
    mon = 1'b1;
    check("rst_green", bus.green, 1);
    check("rst_yellow", bus.yellow, 0);
    check("rst_red", bus.red, 14);
    check("rst_phase", bus.phase, 0);
    check("rst_way", bus.active_way, 0);
    reset = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.green != 4'b0001 || bus.yellow != 4'b0000) bad++;
    end
    check("idle_hold", bad, 0);
    to_green2();
    bus.sensor = 4'b0010;
    span("s2_g2", 0, 2, 4);
    span("s2_y2", 1, 2, 3);
    span("s2_r2", 2, 2, 1);
    bus.sensor = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      span($sformatf("rr%0d_g", i), 0, ways[i], 10);
      span($sformatf("rr%0d_y", i), 1, ways[i], 3);
      span($sformatf("rr%0d_r", i), 2, ways[i], 1);
    end
    span("rr_end", 0, 2, -1);
    do_reset();
    reset = 1'b0;
    bus.emerg_req = 1'b1;
    bus.emerg_way = 2'd3;
    span("em_g0", 0, 0, 1);
    span("em_y0", 1, 0, 3);
    span("em_r0", 2, 0, 1);
    bus.sensor = 4'b1111;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.phase != 2'd0 || bus.active_way != 2'd3) bad++;
    end
    check("em_hold", bad, 0);
    bus.emerg_req = 1'b0;
    @(negedge clk);
    span("em_release", 1, 3, -1);
    to_green2();
    bus.sensor = 4'b1000;
    span("pre_g2", 0, 2, 4);
    bus.emerg_req = 1'b1;
    bus.emerg_way = 2'd0;
    @(negedge clk);
    bus.emerg_req = 1'b0;
    bus.sensor = 4'b0010;
    span("pre_y2", 1, 2, 2);
    span("pre_r2", 2, 2, 1);
    span("pre_g0", 0, 0, -1);
    to_green2();
    bus.sensor = 4'b1000;
    span("ar_g2", 0, 2, 4);
    @(negedge clk);
    check("ar_mid_yellow", bus.yellow, 4);
    #2 reset = 1'b1;
    #1;
    check("ar_green", bus.green, 1);
    check("ar_yellow", bus.yellow, 0);
    check("ar_red", bus.red, 14);
    check("ar_phase", bus.phase, 0);
    check("ar_way", bus.active_way, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.sensor = 4'b0000;
    repeat (5) @(negedge clk);
    span("ar_resume", 0, 0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multi_way_traffic_controller.md
MULTI_WAY_TRAFFIC_CONTROLLER -- requirements
Module: multi_way_traffic_controller

Interface
REQ-001 Parameter N_WAYS, default 4: number of approaches, legal range 2..8.
REQ-002 Parameter MIN_GREEN, default 4: minimum green cycles, legal range 1 or more.
REQ-003 Parameter MAX_GREEN, default 10: green cycles after which a waiting request forces hand-over; legal when MAX_GREEN >= MIN_GREEN.
REQ-004 Parameter YELLOW_CYCLES, default 3: yellow duration, legal range 1 or more.
REQ-005 Parameter ALLRED_CYCLES, default 1: all-red clearance duration, legal range 0 or more.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 sensor  input  N_WAYS  bit i=1: vehicle waiting at way i; sampled every cycle.
REQ-009 emerg_req  input  1  emergency pre-emption request.
REQ-010 emerg_way  input  clog2(N_WAYS)  way to serve on pre-emption; values >= N_WAYS are ignored.
REQ-011 red, yellow, green  output  N_WAYS each  lamp drives, one bit per way.
REQ-012 active_way  output  clog2(N_WAYS)  way currently owning green, yellow or the most recent all-red.
REQ-013 phase  output  2  current state encoding: GREEN=0, YELLOW=1, ALLRED=2.

Function
REQ-014 Each way shall show exactly one lamp every cycle; at most one way is non-red.
REQ-015 FSM states: GREEN, YELLOW, ALLRED. A phase timer counts cycles spent in the current state.
REQ-016 GREEN: green[active_way]=1 and all other ways red.
REQ-017 GREEN->YELLOW at timer>=MIN_GREEN-1 when another way requests and own sensor=0.
REQ-018 GREEN->YELLOW at timer>=MAX_GREEN-1 when another way requests, regardless of own sensor.
REQ-019 With no other request, GREEN shall hold indefinitely (rest-on-green); the timer saturates at MAX_GREEN.
REQ-020 On GREEN exit, next_way latches the first requesting way searching active_way+1 upward, wrapping modulo N_WAYS.
REQ-021 YELLOW shall last exactly YELLOW_CYCLES cycles, then go to ALLRED; with ALLRED_CYCLES=0 it goes straight to GREEN.
REQ-022 ALLRED shall last exactly ALLRED_CYCLES cycles with every way red, then go to GREEN with active_way=next_way and the timer cleared.
REQ-023 Pre-emption: emerg_req=1 with a valid emerg_way != active_way in GREEN forces YELLOW on the next edge, ignoring MIN_GREEN; next_way=emerg_way.
REQ-024 Pre-emption in YELLOW or ALLRED overrides the latched next_way with emerg_way; durations are unchanged.
REQ-025 emerg_req with emerg_way==active_way in GREEN holds green, overriding REQ-017/018, while asserted.
REQ-026 Pre-emption has priority over sensor-based arbitration in the same cycle.
REQ-027 Sensor changes during YELLOW or ALLRED shall not alter next_way; only REQ-024 can change it.
REQ-028 Outputs are registered: lamp changes appear the cycle after the transition decision.

Reset
REQ-029 While reset=1: state=GREEN, active_way=0, next_way=0, timer=0.
REQ-030 While reset=1: green=...0001, yellow=0, red=all ones except bit 0.
REQ-031 Assertion of reset mid-phase shall take effect immediately and asynchronously; normal operation resumes on the first edge after deassertion.

Structure
REQ-032 Package traffic_pkg shall hold the phase enum (GREEN/YELLOW/ALLRED) and the phase encoding constants.
REQ-033 Timer width shall be clog2 of the largest of MAX_GREEN, YELLOW_CYCLES and ALLRED_CYCLES, plus 1.
REQ-034 Sub-module rr_next_way: combinational round-robin search, inputs sensor and active_way, outputs found and next.

Verification (N_WAYS=4, defaults)
REQ-035 Reset, sensor=0 for 50 cycles -> way 0 green throughout, no yellow.
REQ-036 Way 0 green, sensor=0100 -> green0 lasts 4 cycles, yellow0 3 cycles, all-red 1 cycle, then green2.
REQ-037 Green on way 1, sensor=1111 held -> green1 lasts 10 cycles, then 3 yellow, 1 all-red, then green2; service continues 3,0,1.
REQ-038 Way 0 green at cycle 1, emerg_req=1 with emerg_way=3 -> yellow0 on the next edge, then all-red, then green3; green3 holds while emerg_req stays asserted.
REQ-039 Way 2 yellow, emerg_way=0 pulse -> green0 after the remaining yellow and all-red, not way 3.
REQ-040 Reset asserted mid-YELLOW of way 2 -> green0 and red on all other ways immediately; the one-lamp-per-way assertion holds every cycle.
